redmule_ldst_scheduler: RTL

Single-port TCDM scheduler for the RedMulE streamer. Three load requesters (X, W, Y sources) and one store requester (Z sink) share one HCI-style TCDM initiator port. Loads are arbitrated round-robin and a starvation counter bounds store latency. Requests are locked until granted, and an in-order tag FIFO routes read responses back to the issuing source.

---
 rtl/redmule_ldst_scheduler.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/redmule_ldst_scheduler.sv
// redmule_ldst_scheduler
//
// Shares one TCDM initiator port between NUM_LD load requesters (0 = X, 1 = W, 2 = Y) and one
// store requester (Z). Loads are served round-robin. A starvation counter forces the store
// through after STORE_STARVE_MAX waiting cycles. A request that is not granted is locked, and
// its payload is held until the handshake. An in-order tag FIFO routes read responses back to
// the load that issued them.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous clear of all state
//   enable_i               gates new arbitration (does not affect a locked request)
//   ld_req_i/ld_add_i      per-load request and address (source i at [i*AW +: AW])
//   ld_gnt_o               per-load grant (handshake cycle)
//   ld_r_valid_o           per-load response valid; ld_r_data_o is shared by all loads
//   st_req_i/add/data/be   store request and payload; st_gnt_o is the store grant
//   tcdm_*                 TCDM initiator port (tcdm_wen_o = 1 means read)
//   busy_o                 lock held or responses outstanding
//   outstanding_o          tag FIFO occupancy
//   err_o                  sticky: a response arrived while no tag was outstanding
module redmule_ldst_scheduler #(
    parameter int unsigned NUM_LD           = 3,
    parameter int unsigned DW               = 288,
    parameter int unsigned AW               = 32,
    parameter int unsigned MAX_OUTSTANDING  = 4,
    parameter int unsigned STORE_STARVE_MAX = 8,
    localparam int unsigned TW              = $clog2(NUM_LD + 1),
    localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [NUM_LD-1:0]    ld_req_i,
    input  logic [NUM_LD*AW-1:0] ld_add_i,
    output logic [NUM_LD-1:0]    ld_gnt_o,
    output logic [NUM_LD-1:0]    ld_r_valid_o,
    output logic [DW-1:0]        ld_r_data_o,
    input  logic                 st_req_i,
    input  logic [AW-1:0]        st_add_i,
    input  logic [DW-1:0]        st_data_i,
    input  logic [DW/8-1:0]      st_be_i,
    output logic                 st_gnt_o,
    output logic                 tcdm_req_o,
    output logic [AW-1:0]        tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [DW-1:0]        tcdm_data_o,
    output logic [DW/8-1:0]      tcdm_be_o,
    input  logic                 tcdm_gnt_i,
    input  logic                 tcdm_r_valid_i,
    input  logic [DW-1:0]        tcdm_r_data_i,
    output logic                 busy_o,
    output logic [OW-1:0]        outstanding_o,
    output logic                 err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SW = $clog2(STORE_STARVE_MAX + 1);
    localparam logic [TW-1:0] ST_TAG = TW'(NUM_LD);

    // State
    logic [TW-1:0] rr_q, rr_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          lock_q, lock_d;
    logic [TW-1:0] sel_q, sel_d;
    logic [TW-1:0] tag_q [MAX_OUTSTANDING];
    logic [TW-1:0] tag_d [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          err_q, err_d;

    // Combinational
    logic              not_full;
    logic [NUM_LD-1:0] ld_elig;
    logic              st_elig;
    logic              ld_found;
    logic [TW-1:0]     ld_win;
    logic              arb_valid;
    logic [TW-1:0]     arb_sel;
    logic [TW-1:0]     sel;
    logic              hs;
    logic              push;
    logic              pop;
    logic [TW-1:0]     head;

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Strict limit: a pop in this cycle does not open a slot until it is registered.
    assign not_full = (occ_q < OW'(MAX_OUTSTANDING));
    assign ld_elig  = ld_req_i & {NUM_LD{not_full}};
    assign st_elig  = st_req_i & not_full;

    // Round-robin search starting at rr_q.
    always_comb begin : p_ld_arb
        int unsigned idx;
        idx      = 0;
        ld_found = 1'b0;
        ld_win   = '0;
        for (int unsigned k = 0; k < NUM_LD; k++) begin
            idx = (32'(rr_q) + k) % NUM_LD;
            if (!ld_found && ld_elig[idx]) begin
                ld_found = 1'b1;
                ld_win   = TW'(idx);
            end
        end
    end

    always_comb begin : p_arb
        arb_valid = 1'b0;
        arb_sel   = '0;
        if (st_elig && ((starve_q == SW'(STORE_STARVE_MAX)) || !ld_found)) begin
            arb_valid = 1'b1;
            arb_sel   = ST_TAG;
        end else if (ld_found) begin
            arb_valid = 1'b1;
            arb_sel   = ld_win;
        end
    end

    // A locked request keeps driving regardless of enable_i or eligibility.
    always_comb begin : p_issue
        tcdm_req_o = 1'b0;
        sel        = arb_sel;
        if (lock_q) begin
            tcdm_req_o = 1'b1;
            sel        = sel_q;
        end else if (enable_i) begin
            tcdm_req_o = arb_valid;
        end
    end

    assign hs = tcdm_req_o && tcdm_gnt_i;

    always_comb begin : p_payload
        tcdm_add_o  = st_add_i;
        tcdm_wen_o  = 1'b0;
        tcdm_data_o = st_data_i;
        tcdm_be_o   = st_be_i;
        ld_gnt_o    = '0;
        for (int unsigned i = 0; i < NUM_LD; i++) begin
            if (sel == TW'(i)) begin
                tcdm_add_o  = ld_add_i[i*AW +: AW];
                tcdm_wen_o  = 1'b1;
                tcdm_be_o   = '1;
                ld_gnt_o[i] = hs;
            end
        end
    end

    assign st_gnt_o = hs && (sel == ST_TAG);

    // Response routing
    assign head = tag_q[rd_ptr_q];
    assign push = hs;
    assign pop  = tcdm_r_valid_i && (occ_q != '0);

    always_comb begin : p_route
        ld_r_valid_o = '0;
        for (int unsigned i = 0; i < NUM_LD; i++) begin
            if (pop && (head == TW'(i))) begin
                ld_r_valid_o[i] = 1'b1;
            end
        end
    end

    assign ld_r_data_o   = tcdm_r_data_i;
    assign busy_o        = lock_q || (occ_q != '0);
    assign outstanding_o = occ_q;
    assign err_o         = err_q;

    // Next state
    always_comb begin : p_next
        rr_d     = rr_q;
        starve_d = starve_q;
        lock_d   = lock_q;
        sel_d    = sel_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;

        if (hs && (sel != ST_TAG)) begin
            rr_d = (sel == TW'(NUM_LD - 1)) ? '0 : sel + TW'(1);
        end

        if (st_gnt_o) begin
            starve_d = '0;
        end else if (st_req_i && (starve_q != SW'(STORE_STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end

        if (hs) begin
            lock_d = 1'b0;
        end else if (tcdm_req_o) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end

        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OW'(1);
        end

        if (tcdm_r_valid_i && (occ_q == '0)) begin
            err_d = 1'b1;
        end

        if (clear_i) begin
            rr_d     = '0;
            starve_d = '0;
            lock_d   = 1'b0;
            sel_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            starve_q <= '0;
            lock_q   <= 1'b0;
            sel_q    <= '0;
            tag_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

endmodule
